shift_reg: RTL and testbench
============================

# shift_reg

Parametrised universal shift register: the multi-bit, multi-mode successor to the single-bit D flip-flop. It holds a WIDTH-bit word, accepts a parallel load, and on a start request performs a multi-cycle shift or rotate of a requested number of positions with a busy/done handshake. It sits in the flip-flop chapter as the next storage element after the D flip-flop, and builds on it directly: one flop per bit plus a small control FSM.

## Interface
- WIDTH, 8: register width in bits; ≥ 2.
- CW, 4: width of the shift-amount port; 2^CW > WIDTH is required.
- RESET_VALUE, 0: value of q after reset; WIDTH bits.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- load  in  1  parallel-load request; honoured only in IDLE.
- data_in  in  WIDTH  parallel-load data.
- start  in  1  shift request; honoured only in IDLE.
- mode  in  2  operation: 00 shift left, 01 shift right, 10 rotate left, 11 rotate right; sampled with start.
- amount  in  CW  number of single-position steps; sampled with start.
- serial_in  in  1  fill bit for shift modes; sampled on every shift edge.
- q  out  WIDTH  register contents.
- serial_out  out  1  bit most recently shifted or rotated out; registered.
- busy  out  1  high while shifting.
- done  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE: busy=0.
  - SHIFT: busy=1, down-counter cnt (CW bits).
- IDLE, load=1: q ← data_in on the edge, then stay in IDLE. load has priority: start is ignored in the same cycle.
- IDLE, start=1, load=0, amount>0: latch mode into mode_r and amount into cnt, then go to SHIFT. q is unchanged on this edge.
- IDLE, start=1, load=0, amount=0: stay in IDLE and set done=1 for the next cycle. q is unchanged and busy never rises.
- SHIFT, each edge: perform one step per mode_r, then cnt ← cnt−1.
  - When cnt=1 before the edge: go to IDLE and set done=1 for the next cycle.
- Steps:
  - Shift left: q ← {q[W−2:0], serial_in}, serial_out ← q[W−1].
  - Shift right: q ← {serial_in, q[W−1:1]}, serial_out ← q[0].
  - Rotate left: q ← {q[W−2:0], q[W−1]}, serial_out ← q[W−1].
  - Rotate right: q ← {q[0], q[W−1:1]}, serial_out ← q[0].
- amount > WIDTH is legal.
  - Shift modes fill entirely with serial_in history.
  - Rotate modes wrap: the net effect is a rotation by amount mod WIDTH.
- load, start, mode and amount are ignored while busy. mode and amount changing mid-operation have no effect.
- serial_out holds its value outside shift edges.
- done is high for exactly one cycle per accepted start. It is otherwise 0.
- Reset, any time including mid-SHIFT:
  - q=RESET_VALUE, serial_out=0, busy=0, done=0, cnt=0, state IDLE.
  - The operation is aborted and no done is produced.

## Timing
- Load latency: 1 edge.
- Start sampled on edge T0.
  - busy=1 from after T0.
  - Shifts occur on edges T1..TN, where N=amount.
  - After TN: busy=0 and done=1 for one cycle.
- A new start is accepted on the edge where done is high; back-to-back operations have period N+1 edges.
- amount=0: done high in the cycle after T0.
- Reset is asynchronous: outputs reach their reset values without waiting for clk. Release is synchronous to the next edge.

## Test plan
- Async reset: q=0x5A, assert rst mid-cycle → q=0x00, busy=0, done=0, serial_out=0 before the next clk edge.
- Load: load=1, data_in=0xA5 → q=0xA5 after one edge, busy stays 0, done stays 0.
- Shift left, q=0x81, mode=00, amount=3, serial_in=1:
  - q sequence 0x03, 0x07, 0x0F.
  - serial_out 1, 0, 0.
  - busy high for 3 cycles, done high the cycle after the third shift.
- Rotate wrap, q=0x81, mode=11, amount=9 → final q=0xC0, done after 9 shift edges.
- Zero amount plus ignore rules:
  - start with amount=0 → done next cycle, q unchanged, busy never 1.
  - During a mode=01, amount=4 operation, pulse load=1 data_in=0xFF and start=1 → both ignored, the result is unaffected.
- Reset mid-operation, q=0xF0, mode=00, amount=5: assert rst after the second shift → q=0x00, busy=0, no done pulse. Then a new load=0x3C succeeds.

Source files
------------

// File: rtl/shift_reg.sv
// shift_reg: universal shift/rotate register with parallel load and a busy/done handshake.
module shift_reg #(
  parameter int WIDTH = 8,
  parameter int CW = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CW-1:0]    amount,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_q, w_step;
  logic [CW-1:0] r_cnt;
  logic [1:0] r_mode;
  logic r_so, r_done, w_accept, w_last, w_out_bit;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // mode bit 1 selects rotate, bit 0 selects right
  always_comb begin
    w_accept = (r_state == IDLE) && start && !load;
    w_last = (r_state == SHIFT) && (r_cnt == CW'(1));
    w_next = r_state;
    if (w_accept && amount != '0) w_next = SHIFT;
    if (w_last) w_next = IDLE;
    w_out_bit = r_mode[0] ? r_q[0] : r_q[WIDTH-1];
    w_step = r_mode[0] ? {(r_mode[1] ? r_q[0] : serial_in), r_q[WIDTH-1:1]}
                       : {r_q[WIDTH-2:0], (r_mode[1] ? r_q[WIDTH-1] : serial_in)};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_q <= RESET_VALUE;
      r_so <= 1'b0;
      r_done <= 1'b0;
      r_cnt <= '0;
      r_mode <= '0;
    end else begin
      r_done <= (w_accept && amount == '0) || w_last;
      if (r_state == IDLE) begin
        if (load) r_q <= data_in;
        else if (start) begin
          r_mode <= mode;
          r_cnt <= amount;
        end
      end else begin
        r_q <= w_step;
        r_so <= w_out_bit;
        r_cnt <= r_cnt - CW'(1);
      end
    end
  assign q = r_q;
  assign serial_out = r_so;
  assign busy = (r_state == SHIFT);
  assign done = r_done;
endmodule

// File: tb/tb_shift_reg.sv
// tb_shift_reg: directed vector table plus hand sequences for reset and wrap cases.
module tb_shift_reg;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, start = 1'b0, serial_in = 1'b0;
  logic [7:0] data_in = '0;
  logic [1:0] mode = '0;
  logic [3:0] amount = '0;
  logic [7:0] q;
  logic serial_out, busy, done;
  int total = 0, bad = 0;
  shift_reg #(.WIDTH(8), .CW(4), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .start(start),
    .mode(mode), .amount(amount), .serial_in(serial_in), .q(q),
    .serial_out(serial_out), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic ld; logic [7:0] din; logic st; logic [1:0] md; logic [3:0] amt; logic si;
    logic [7:0] eq; logic eso; logic ebusy; logic edone;
  } vec_t;
  vec_t vecs [16];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic ld, input logic [7:0] din, input logic st,
                       input logic [1:0] md, input logic [3:0] amt, input logic si);
    load = ld; data_in = din; start = st; mode = md; amount = amt; serial_in = si;
  endtask
  initial begin
    logic seen_done;
    vecs[0]  = '{1'b1, 8'h81, 1'b0, 2'd0, 4'd0, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 2'd0, 4'd3, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 2'd0, 4'd0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 2'd0, 4'd0, 1'b1, 8'h07, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 2'd0, 4'd0, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 2'd0, 4'd0, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'hC3, 1'b0, 2'd0, 4'd0, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 2'd2, 4'd0, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 2'd0, 4'd0, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 2'd1, 4'd4, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 2'd0, 4'd0, 1'b0, 8'h61, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 8'hFF, 1'b1, 2'd0, 4'd1, 1'b0, 8'h30, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 2'd0, 4'd0, 1'b0, 8'h18, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 2'd0, 4'd0, 1'b0, 8'h0C, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 2'd0, 4'd0, 1'b0, 8'h0C, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 8'h55, 1'b1, 2'd0, 4'd2, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0};
    #3;
    chk("reset q", 32'(q), 32'h00);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset so", 32'(serial_out), 0);
    tick;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].ld, vecs[i].din, vecs[i].st, vecs[i].md, vecs[i].amt, vecs[i].si);
      tick;
      chk($sformatf("row%0d q", i), 32'(q), 32'(vecs[i].eq));
      chk($sformatf("row%0d so", i), 32'(serial_out), 32'(vecs[i].eso));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].ebusy));
      chk($sformatf("row%0d done", i), 32'(done), 32'(vecs[i].edone));
    end
    // rotate right by 9 wraps to a rotation by 1
    drive(1'b1, 8'h81, 1'b0, 2'd0, 4'd0, 1'b0);
    tick;
    drive(1'b0, 8'h00, 1'b1, 2'd3, 4'd9, 1'b0);
    tick;
    drive(1'b0, 8'h00, 1'b0, 2'd0, 4'd0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      tick;
      chk($sformatf("rot edge%0d busy", i), 32'(busy), 32'(i < 9));
      chk($sformatf("rot edge%0d done", i), 32'(done), 32'(i == 9));
    end
    chk("rot q", 32'(q), 32'hC0);
    chk("rot so", 32'(serial_out), 1);
    // asynchronous reset mid-cycle
    drive(1'b1, 8'h5A, 1'b0, 2'd0, 4'd0, 1'b0);
    tick;
    load = 1'b0;
    chk("pre-areset q", 32'(q), 32'h5A);
    #2 rst = 1'b1;
    #1;
    chk("areset q", 32'(q), 32'h00);
    chk("areset so", 32'(serial_out), 0);
    chk("areset busy", 32'(busy), 0);
    chk("areset done", 32'(done), 0);
    tick;
    rst = 1'b0;
    // reset aborting an operation
    drive(1'b1, 8'hF0, 1'b0, 2'd0, 4'd0, 1'b0);
    tick;
    drive(1'b0, 8'h00, 1'b1, 2'd0, 4'd5, 1'b0);
    tick;
    start = 1'b0;
    tick;
    tick;
    chk("midop q", 32'(q), 32'hC0);
    chk("midop busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("midop rst q", 32'(q), 32'h00);
    chk("midop rst busy", 32'(busy), 0);
    tick;
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      seen_done |= done | busy;
    end
    chk("no done after abort", 32'(seen_done), 0);
    drive(1'b1, 8'h3C, 1'b0, 2'd0, 4'd0, 1'b0);
    tick;
    load = 1'b0;
    chk("load after abort", 32'(q), 32'h3C);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
